// File: rtl/forwarding_unit_pkg.sv
// Shared definitions for the EX-stage forwarding unit.
// Combinational select codes and register-index width; no timing of its own.
// No flow control: purely constant/function definitions.
//
// Contents:
//   REG_W      register-index width (MIPS: 32 registers)
//   fwdSel_t   2-bit ALU operand select code
//   FWD_*      select-code constants
//   satInc     saturating increment helper for the event counters
package forwarding_unit_pkg;

  localparam int REG_W = 5;

  typedef logic [1:0] fwdSel_t;

  localparam fwdSel_t FWD_RF    = 2'b00;
  localparam fwdSel_t FWD_EXMEM = 2'b10;
  localparam fwdSel_t FWD_MEMWB = 2'b01;

  // Clamp at all-ones instead of wrapping so a long-running counter
  // never reads back as a small value.
  function automatic logic [63:0] satInc(input logic [63:0] cur, input int width);
    logic [63:0] maxVal;
    maxVal = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (cur >= maxVal) ? maxVal : cur + 64'd1;
  endfunction

endpackage

// File: rtl/forwarding_unit_fwd_select.sv
// Per-operand forwarding decision: picks register file, EX/MEM or MEM/WB.
// Latency: combinational, zero cycles.
// No flow control: output follows inputs every cycle.
//
// Ports:
//   exRegWrite, exRd   EX/MEM write enable and destination register
//   memRegWrite, memRd MEM/WB write enable and destination register
//   srcReg             ID/EX source register being resolved
//   fwdSel             resulting select code (never 2'b11)
module fwd_select
  import forwarding_unit_pkg::*;
(
  input  logic             exRegWrite,
  input  logic [REG_W-1:0] exRd,
  input  logic             memRegWrite,
  input  logic [REG_W-1:0] memRd,
  input  logic [REG_W-1:0] srcReg,
  output fwdSel_t          fwdSel
);

  // Priority chain: EX/MEM holds the youngest value, so it is tested first.
  // Structured as if/else so an unknown MEM/WB write enable cannot leak into
  // the result when EX/MEM already wins. Register 0 is hardwired to zero and
  // is never forwarded.
  always_comb begin
    fwdSel = FWD_RF;
    if (exRegWrite && (exRd != '0) && (exRd == srcReg)) begin
      fwdSel = FWD_EXMEM;
    end else if (memRegWrite && (memRd != '0) && (memRd == srcReg)) begin
      fwdSel = FWD_MEMWB;
    end else begin
      fwdSel = FWD_RF;
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// EX-stage data-hazard forwarding: operand select codes, operand muxes, event counters.
// Latency: selects and operands are combinational (valid under reset); counters update on clk.
// No flow control: evaluates every cycle; counters saturate at all-ones.
//
// Ports:
//   clk, reset                 counter clock; async active-high counter clear
//   EXMEMRegWrite, EXMEMRD     EX/MEM write enable / destination register
//   MEMWBRegWrite, MEMWBRD     MEM/WB write enable / destination register
//   IDEXRS, IDEXRT             ID/EX source registers
//   rs_data, rt_data           register-file operand values
//   exmem_alu, memwb_wdata     forwardable results from EX/MEM and MEM/WB
//   forwardA, forwardB         select codes (00 RF, 10 EX/MEM, 01 MEM/WB)
//   alu_a, alu_b               forwarded ALU operands
//   fwd_ex_count               cycles with at least one EX/MEM forward
//   fwd_mem_count              cycles with at least one MEM/WB forward
module forwarding_unit
  import forwarding_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  input  logic              EXMEMRegWrite,
  input  logic              MEMWBRegWrite,
  input  logic [REG_W-1:0]  EXMEMRD,
  input  logic [REG_W-1:0]  MEMWBRD,
  input  logic [REG_W-1:0]  IDEXRS,
  input  logic [REG_W-1:0]  IDEXRT,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] exmem_alu,
  input  logic [DATA_W-1:0] memwb_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CNT_W-1:0]  fwd_ex_count,
  output logic [CNT_W-1:0]  fwd_mem_count
);

  fwdSel_t selA;
  fwdSel_t selB;
  logic    exHit;
  logic    memHit;

  fwd_select uFwdSelA (
    .exRegWrite  (EXMEMRegWrite),
    .exRd        (EXMEMRD),
    .memRegWrite (MEMWBRegWrite),
    .memRd       (MEMWBRD),
    .srcReg      (IDEXRS),
    .fwdSel      (selA)
  );

  fwd_select uFwdSelB (
    .exRegWrite  (EXMEMRegWrite),
    .exRd        (EXMEMRD),
    .memRegWrite (MEMWBRegWrite),
    .memRd       (MEMWBRD),
    .srcReg      (IDEXRT),
    .fwdSel      (selB)
  );

  assign forwardA = selA;
  assign forwardB = selB;

  // Code 2'b11 cannot occur; falling back to the register file keeps the
  // mux fully specified.
  always_comb begin
    alu_a = rs_data;
    case (selA)
      FWD_EXMEM: alu_a = exmem_alu;
      FWD_MEMWB: alu_a = memwb_wdata;
      default:   alu_a = rs_data;
    endcase
  end

  always_comb begin
    alu_b = rt_data;
    case (selB)
      FWD_EXMEM: alu_b = exmem_alu;
      FWD_MEMWB: alu_b = memwb_wdata;
      default:   alu_b = rt_data;
    endcase
  end

  // One increment per cycle per source, however many operands used it.
  assign exHit  = (selA == FWD_EXMEM) || (selB == FWD_EXMEM);
  assign memHit = (selA == FWD_MEMWB) || (selB == FWD_MEMWB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_ex_count  <= '0;
      fwd_mem_count <= '0;
    end else begin
      if (exHit && (fwd_ex_count != '1)) begin
        fwd_ex_count <= fwd_ex_count + 1'b1;
      end
      if (memHit && (fwd_mem_count != '1)) begin
        fwd_mem_count <= fwd_mem_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed self-checking bench for forwarding_unit.
// Combinational checks are sampled 1 time unit after inputs change; counter checks 1 unit after posedge.
// Counter width is reduced so saturation is reachable in a few cycles.
module tb_forwarding_unit;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [DATA_W-1:0] RS_VAL  = 32'h1111_1111;
  localparam logic [DATA_W-1:0] RT_VAL  = 32'h2222_2222;
  localparam logic [DATA_W-1:0] EX_VAL  = 32'hAAAA_0001;
  localparam logic [DATA_W-1:0] MEM_VAL = 32'h5555_0002;

  logic              clk;
  logic              reset;
  logic [1:0]        forwardA;
  logic [1:0]        forwardB;
  logic              EXMEMRegWrite;
  logic              MEMWBRegWrite;
  logic [4:0]        EXMEMRD;
  logic [4:0]        MEMWBRD;
  logic [4:0]        IDEXRS;
  logic [4:0]        IDEXRT;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] exmem_alu;
  logic [DATA_W-1:0] memwb_wdata;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CNT_W-1:0]  fwd_ex_count;
  logic [CNT_W-1:0]  fwd_mem_count;

  int testsRun;
  int testsFailed;

  forwarding_unit #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .forwardA      (forwardA),
    .forwardB      (forwardB),
    .EXMEMRegWrite (EXMEMRegWrite),
    .MEMWBRegWrite (MEMWBRegWrite),
    .EXMEMRD       (EXMEMRD),
    .MEMWBRD       (MEMWBRD),
    .IDEXRS        (IDEXRS),
    .IDEXRT        (IDEXRT),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .exmem_alu     (exmem_alu),
    .memwb_wdata   (memwb_wdata),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .fwd_ex_count  (fwd_ex_count),
    .fwd_mem_count (fwd_mem_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setIdle();
    EXMEMRegWrite = 1'b0;
    MEMWBRegWrite = 1'b0;
    EXMEMRD       = 5'd0;
    MEMWBRD       = 5'd0;
    IDEXRS        = 5'd0;
    IDEXRT        = 5'd0;
  endtask

  task automatic setHazard(input logic exW, input logic [4:0] exRd,
                           input logic memW, input logic [4:0] memRd,
                           input logic [4:0] rs, input logic [4:0] rt);
    EXMEMRegWrite = exW;
    EXMEMRD       = exRd;
    MEMWBRegWrite = memW;
    MEMWBRD       = memRd;
    IDEXRS        = rs;
    IDEXRT        = rt;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    rs_data     = RS_VAL;
    rt_data     = RT_VAL;
    exmem_alu   = EX_VAL;
    memwb_wdata = MEM_VAL;
    setIdle();
    #1;
    checkEq("reset_ex_count",  64'(fwd_ex_count),  64'd0);
    checkEq("reset_mem_count", 64'(fwd_mem_count), 64'd0);
    checkEq("idle_fwdA", 64'(forwardA), 64'(2'b00));

    // Combinational cases under reset: outputs must still be valid.
    setHazard(1'b1, 5'd5, 1'bx, 5'd5, 5'd5, 5'd5);
    #1;
    checkEq("ex_hit_fwdA",  64'(forwardA), 64'(2'b10));
    checkEq("ex_hit_fwdB",  64'(forwardB), 64'(2'b10));
    checkEq("ex_hit_alu_a", 64'(alu_a),    64'(EX_VAL));
    checkEq("ex_hit_alu_b", 64'(alu_b),    64'(EX_VAL));

    setHazard(1'b0, 5'd5, 1'b1, 5'd7, 5'd7, 5'd7);
    #1;
    checkEq("mem_hit_fwdA",  64'(forwardA), 64'(2'b01));
    checkEq("mem_hit_fwdB",  64'(forwardB), 64'(2'b01));
    checkEq("mem_hit_alu_a", 64'(alu_a),    64'(MEM_VAL));
    checkEq("mem_hit_alu_b", 64'(alu_b),    64'(MEM_VAL));

    setHazard(1'b0, 5'd5, 1'b0, 5'd7, 5'd7, 5'd7);
    #1;
    checkEq("no_write_fwdA",  64'(forwardA), 64'(2'b00));
    checkEq("no_write_fwdB",  64'(forwardB), 64'(2'b00));
    checkEq("no_write_alu_a", 64'(alu_a),    64'(RS_VAL));
    checkEq("no_write_alu_b", 64'(alu_b),    64'(RT_VAL));

    setHazard(1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd4);
    #1;
    checkEq("prio_fwdA",  64'(forwardA), 64'(2'b10));
    checkEq("prio_fwdB",  64'(forwardB), 64'(2'b00));
    checkEq("prio_alu_a", 64'(alu_a),    64'(EX_VAL));
    checkEq("prio_alu_b", 64'(alu_b),    64'(RT_VAL));

    setHazard(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    checkEq("r0_fwdA",  64'(forwardA), 64'(2'b00));
    checkEq("r0_fwdB",  64'(forwardB), 64'(2'b00));
    checkEq("r0_alu_a", 64'(alu_a),    64'(RS_VAL));

    setHazard(1'b1, 5'd3, 1'b1, 5'd7, 5'd7, 5'd3);
    #1;
    checkEq("split_fwdA", 64'(forwardA), 64'(2'b01));
    checkEq("split_fwdB", 64'(forwardB), 64'(2'b10));

    // Clock has been running with forwards active; reset must have held counters.
    @(posedge clk);
    #1;
    checkEq("held_ex_count",  64'(fwd_ex_count),  64'd0);
    checkEq("held_mem_count", 64'(fwd_mem_count), 64'd0);

    setIdle();
    @(negedge clk);
    reset = 1'b0;

    // rs from EX/MEM, rt from MEM/WB for exactly 3 edges.
    @(negedge clk);
    setHazard(1'b1, 5'd2, 1'b1, 5'd9, 5'd2, 5'd9);
    repeat (3) @(posedge clk);
    #1;
    checkEq("mixed_fwdA",      64'(forwardA),      64'(2'b10));
    checkEq("mixed_fwdB",      64'(forwardB),      64'(2'b01));
    checkEq("mixed_ex_count",  64'(fwd_ex_count),  64'd3);
    checkEq("mixed_mem_count", 64'(fwd_mem_count), 64'd3);
    setIdle();
    @(posedge clk);
    #1;
    checkEq("idle_ex_count", 64'(fwd_ex_count), 64'd3);

    // Both operands from EX/MEM for 2 edges: one count per cycle, MEM/WB loses.
    @(negedge clk);
    setHazard(1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5);
    repeat (2) @(posedge clk);
    #1;
    setIdle();
    checkEq("both_ex_count",  64'(fwd_ex_count),  64'd5);
    checkEq("both_mem_count", 64'(fwd_mem_count), 64'd3);

    // Saturate MEM/WB counter.
    @(negedge clk);
    setHazard(1'b0, 5'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    repeat (20) @(posedge clk);
    #1;
    checkEq("sat_mem_count", 64'(fwd_mem_count), 64'd15);
    checkEq("sat_mem_ex",    64'(fwd_ex_count),  64'd5);

    // Saturate EX/MEM counter.
    @(negedge clk);
    setHazard(1'b1, 5'd2, 1'b0, 5'd0, 5'd2, 5'd0);
    repeat (20) @(posedge clk);
    #1;
    checkEq("sat_ex_count", 64'(fwd_ex_count),  64'd15);
    checkEq("sat_ex_mem",   64'(fwd_mem_count), 64'd15);

    // Asynchronous reset between edges, forwarding still active.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkEq("async_ex_count",  64'(fwd_ex_count),  64'd0);
    checkEq("async_mem_count", 64'(fwd_mem_count), 64'd0);
    @(posedge clk);
    #1;
    checkEq("rst_hold_ex_count", 64'(fwd_ex_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkEq("resume_ex_count", 64'(fwd_ex_count), 64'd1);
    setIdle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
